// File: rtl/mixer_pkg.sv
// Shared types and helpers for the multi-channel 1-bit RF mixer.
// mode_e selects how each lane treats its LO samples; sat_neg is the clipping negate.
package mixer_pkg;

   typedef enum logic [1:0] {
      MIX    = 2'd0,
      PASS   = 2'd1,
      MUTE   = 2'd2,
      INVERT = 2'd3
   } mode_e;

   localparam int W_DEF = 12;
   localparam int SMAX  = (2 ** (W_DEF - 1)) - 1;
   localparam int SMIN  = -(2 ** (W_DEF - 1));

   typedef struct packed {
      logic        clip;
      logic [31:0] value;
   } neg_t;

   // Negate a w-bit signed value held in an int; the most negative code clips to the max.
   function automatic neg_t sat_neg(input int x, input int w);
      neg_t r;
      if (x == -(2 ** (w - 1))) begin
         r.clip  = 1'b1;
         r.value = (2 ** (w - 1)) - 1;
      end else begin
         r.clip  = 1'b0;
         r.value = -x;
      end
      return r;
   endfunction

endpackage

// File: rtl/mixer_lane.sv
// One mixer channel: valid-gated RF delay line, mode mux, saturating I/Q negate
// and a sticky clip flag. Samples move only when in_valid is high; there is no backpressure.
module mixer_lane
   import mixer_pkg::*;
#(
   parameter int W          = 12,
   parameter int RF_DELAY   = 2,
   parameter bit RF_RST_VAL = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic         rf_in,
   input  logic [W-1:0] sin_in,
   input  logic [W-1:0] cos_in,
   input  mode_e        mode,
   input  logic         sat_clr,
   output logic         rf_out,
   output logic [W-1:0] sin_out,
   output logic [W-1:0] cos_out,
   output logic         sat_flag
);

   logic [RF_DELAY-1:0] d;
   logic                s;
   neg_t                neg_i;
   neg_t                neg_q;
   logic [W-1:0]        mix_i;
   logic [W-1:0]        mix_q;
   logic                clip;

   assign s      = d[RF_DELAY-1];
   assign rf_out = d[0];
   assign neg_i  = sat_neg(int'(signed'(sin_in)), W);
   assign neg_q  = sat_neg(int'(signed'(cos_in)), W);

   always_comb begin
      mix_i = sin_in;
      mix_q = cos_in;
      clip  = 1'b0;
      case (mode)
         MIX: begin
            if (s) begin
               mix_i = neg_i.value[W-1:0];
               mix_q = neg_q.value[W-1:0];
               clip  = neg_i.clip | neg_q.clip;
            end
         end
         PASS: begin
            mix_i = sin_in;
            mix_q = cos_in;
         end
         MUTE: begin
            mix_i = '0;
            mix_q = '0;
         end
         INVERT: begin
            mix_i = neg_i.value[W-1:0];
            mix_q = neg_q.value[W-1:0];
            clip  = neg_i.clip | neg_q.clip;
         end
         default: begin
            mix_i = sin_in;
            mix_q = cos_in;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d        <= {RF_DELAY{RF_RST_VAL}};
         sin_out  <= '0;
         cos_out  <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (in_valid) begin
            d[0] <= rf_in;
            for (int i = 1; i < RF_DELAY; i++) d[i] <= d[i-1];
            sin_out <= mix_i;
            cos_out <= mix_q;
         end
         // A clip on the same cycle as a clear keeps the flag set.
         if (in_valid && clip) sat_flag <= 1'b1;
         else if (sat_clr)     sat_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/iq_mixer_mc.sv
// Multi-channel 1-bit RF mixer between the NCOs and the CIC decimators.
// NUM_CH independent lanes plus the shared out_valid register.
module iq_mixer_mc
   import mixer_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 12,
   parameter int RF_DELAY   = 2,
   parameter bit RF_RST_VAL = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [NUM_CH-1:0]            rf_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0] sinewave_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0] cosinewave_in,
   input  logic [2*NUM_CH-1:0]          mode_in,
   input  logic                         sat_clr,
   output logic [NUM_CH-1:0]            rf_out,
   output logic                         out_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0] sinewave_out,
   output logic [NUM_CH*DATA_WIDTH-1:0] cosinewave_out,
   output logic [NUM_CH-1:0]            sat_flag
);

   always_ff @(posedge clk) begin
      if (!rst_n) out_valid <= 1'b0;
      else        out_valid <= in_valid;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      mixer_lane #(
         .W          (DATA_WIDTH),
         .RF_DELAY   (RF_DELAY),
         .RF_RST_VAL (RF_RST_VAL)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .rf_in    (rf_in[c]),
         .sin_in   (sinewave_in[c*DATA_WIDTH +: DATA_WIDTH]),
         .cos_in   (cosinewave_in[c*DATA_WIDTH +: DATA_WIDTH]),
         .mode     (mode_e'(mode_in[2*c +: 2])),
         .sat_clr  (sat_clr),
         .rf_out   (rf_out[c]),
         .sin_out  (sinewave_out[c*DATA_WIDTH +: DATA_WIDTH]),
         .cos_out  (cosinewave_out[c*DATA_WIDTH +: DATA_WIDTH]),
         .sat_flag (sat_flag[c])
      );
   end

endmodule

// File: tb/tb_iq_mixer_mc.sv
// Directed plus random bench for iq_mixer_mc; two instances (RF_DELAY 2 and 4) share stimulus.
// The reference keeps a per-channel queue of valid RF bits preloaded with the reset value.
module tb_iq_mixer_mc;

   localparam int NC = 4;
   localparam int W  = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [NC-1:0] rf_in;
   logic [47:0]   sinewave_in;
   logic [47:0]   cosinewave_in;
   logic [7:0]    mode_in;
   logic          sat_clr;

   logic [NC-1:0] rf_o   [2];
   logic          ov_o   [2];
   logic [47:0]   sin_o  [2];
   logic [47:0]   cos_o  [2];
   logic [NC-1:0] flag_o [2];

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state, index 0 = RF_DELAY 2, index 1 = RF_DELAY 4
   int dly [2] = '{2, 4};
   bit q   [2][NC][$];
   int e_sin [2][NC];
   int e_cos [2][NC];
   bit e_sat [2][NC];
   bit e_ov;

   always #5 clk = ~clk;

   iq_mixer_mc #(.NUM_CH(NC), .DATA_WIDTH(W), .RF_DELAY(2), .RF_RST_VAL(1'b1)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rf_in(rf_in),
      .sinewave_in(sinewave_in), .cosinewave_in(cosinewave_in), .mode_in(mode_in),
      .sat_clr(sat_clr), .rf_out(rf_o[0]), .out_valid(ov_o[0]),
      .sinewave_out(sin_o[0]), .cosinewave_out(cos_o[0]), .sat_flag(flag_o[0])
   );

   iq_mixer_mc #(.NUM_CH(NC), .DATA_WIDTH(W), .RF_DELAY(4), .RF_RST_VAL(1'b1)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rf_in(rf_in),
      .sinewave_in(sinewave_in), .cosinewave_in(cosinewave_in), .mode_in(mode_in),
      .sat_clr(sat_clr), .rf_out(rf_o[1]), .out_valid(ov_o[1]),
      .sinewave_out(sin_o[1]), .cosinewave_out(cos_o[1]), .sat_flag(flag_o[1])
   );

   function automatic logic [47:0] w12(input int v);
      logic [47:0] r;
      r = '0;
      r[11:0] = v[11:0];
      return r;
   endfunction

   function automatic int rnd_x();
      if ($urandom_range(0, 7) == 0) return -2048;
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   // Mixer rule in plain arithmetic: sign flip by mode/RF bit, -(-2048) clips to 2047.
   function automatic int ref_mix(input int x, input int m, input bit s, output bit clip);
      bit neg;
      neg  = (m == 3) || (m == 0 && s);
      clip = neg && (x == -2048);
      if (m == 2) return 0;
      if (!neg)   return x;
      if (clip)   return 2047;
      return -x;
   endfunction

   task automatic set_ch(input int c, input int xs, input int xc, input int m);
      sinewave_in[c*12 +: 12]   = 12'(xs);
      cosinewave_in[c*12 +: 12] = 12'(xc);
      mode_in[2*c +: 2]         = 2'(m);
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  xs, xc, m;
      bit  s, cs, cc;
      if (!rst_n) begin
         e_ov = 1'b0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) begin
               q[d][c].delete();
               repeat (dly[d]) q[d][c].push_back(1'b1);
               e_sin[d][c] = 0;
               e_cos[d][c] = 0;
               e_sat[d][c] = 1'b0;
            end
      end else begin
         e_ov = in_valid;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) begin
               cs = 1'b0;
               cc = 1'b0;
               if (in_valid) begin
                  xs = int'(signed'(sinewave_in[c*12 +: 12]));
                  xc = int'(signed'(cosinewave_in[c*12 +: 12]));
                  m  = int'(mode_in[2*c +: 2]);
                  s  = q[d][c].pop_front();
                  q[d][c].push_back(rf_in[c]);
                  e_sin[d][c] = ref_mix(xs, m, s, cs);
                  e_cos[d][c] = ref_mix(xc, m, s, cc);
               end
               if (cs || cc)     e_sat[d][c] = 1'b1;
               else if (sat_clr) e_sat[d][c] = 1'b0;
            end
      end
   endtask

   task automatic check_all(input string tag);
      logic [47:0] es, ec, erf, ef;
      for (int d = 0; d < 2; d++) begin
         es = '0; ec = '0; erf = '0; ef = '0;
         for (int c = 0; c < NC; c++) begin
            es[c*12 +: 12] = 12'(e_sin[d][c]);
            ec[c*12 +: 12] = 12'(e_cos[d][c]);
            erf[c] = q[d][c][$];
            ef[c]  = e_sat[d][c];
         end
         chk($sformatf("%s_d%0d_sin", tag, d), sin_o[d], es);
         chk($sformatf("%s_d%0d_cos", tag, d), cos_o[d], ec);
         chk($sformatf("%s_d%0d_rf", tag, d), 48'(rf_o[d]), erf);
         chk($sformatf("%s_d%0d_ov", tag, d), 48'(ov_o[d]), 48'(e_ov));
         chk($sformatf("%s_d%0d_flag", tag, d), 48'(flag_o[d]), ef);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   int t2_sin [5] = '{-100, -100, 100, 100, -100};
   int t2_cos [5] = '{50, 50, -50, -50, 50};
   bit t2_rf  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      // reset with random inputs
      rst_n = 1'b0; sat_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         rf_in    = 4'($urandom_range(0, 15));
         for (int c = 0; c < NC; c++) set_ch(c, rnd_x(), rnd_x(), $urandom_range(0, 3));
         sat_clr  = 1'($urandom_range(0, 1));
         step("rst");
      end
      chk("rst_rf_out", 48'(rf_o[0]), 48'hF);
      chk("rst_sin_zero", sin_o[0], 48'h0);
      chk("rst_ov_zero", 48'(ov_o[0]), 48'h0);

      // MIX on ch0 with a known RF pattern
      rst_n = 1'b1; sat_clr = 1'b0; in_valid = 1'b1;
      for (int c = 1; c < NC; c++) set_ch(c, rnd_x(), rnd_x(), 0);
      set_ch(0, 100, -50, 0);
      for (int k = 0; k < 5; k++) begin
         rf_in = {3'($urandom_range(0, 7)), t2_rf[k]};
         step("mix");
         chk("mix_sin_ch0", 48'(sin_o[0][11:0]), w12(t2_sin[k]));
         chk("mix_cos_ch0", 48'(cos_o[0][11:0]), w12(t2_cos[k]));
         chk("mix_rf_lag", 48'(rf_o[0][0]), 48'(t2_rf[k]));
      end

      // saturation and sticky flag
      in_valid = 1'b0; sat_clr = 1'b1;
      step("clr");
      sat_clr = 1'b0; in_valid = 1'b1; rf_in = 4'hF;
      set_ch(1, 5, 5, 0);
      step("sat_pre");
      step("sat_pre");
      set_ch(1, -2048, 7, 0);
      step("sat");
      chk("sat_sin_ch1", 48'(sin_o[0][23:12]), w12(2047));
      chk("sat_flag_set", 48'(flag_o[0][1]), 48'h1);
      sat_clr = 1'b1;
      step("sat_clr_clip");
      chk("sat_clr_clip", 48'(flag_o[0][1]), 48'h1);
      set_ch(1, 5, 5, 0);
      step("sat_clr");
      chk("sat_clr_none", 48'(flag_o[0][1]), 48'h0);
      sat_clr = 1'b0;

      // valid gaps with RF toggling every clock
      begin
         bit iv_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         bit prev_iv;
         for (int k = 0; k < 5; k++) begin
            prev_iv  = iv_seq[k];
            in_valid = iv_seq[k];
            rf_in    = (k % 2 == 0) ? 4'h5 : 4'hA;
            for (int c = 0; c < NC; c++) set_ch(c, rnd_x(), rnd_x(), $urandom_range(0, 3));
            step("gap");
            chk("gap_ov", 48'(ov_o[0]), 48'(prev_iv));
         end
      end

      // all four modes, then ch2 switched to PASS
      in_valid = 1'b1; rf_in = 4'hF;
      for (int c = 0; c < NC; c++) set_ch(c, 300, 300, c);
      step("mode_pre");
      step("mode_pre");
      step("mode");
      chk("mode_mix", 48'(sin_o[0][11:0]), w12(-300));
      chk("mode_pass", 48'(sin_o[0][23:12]), w12(300));
      chk("mode_mute", 48'(sin_o[0][35:24]), w12(0));
      chk("mode_inv", 48'(sin_o[0][47:36]), w12(-300));
      set_ch(2, 300, 300, 1);
      step("mode_sw");
      chk("mode_sw_ch2", 48'(sin_o[0][35:24]), w12(300));

      // reset mid-stream on the 4-deep instance
      for (int c = 0; c < NC; c++) set_ch(c, 300, -300, 0);
      for (int k = 0; k < 10; k++) begin
         rf_in = 4'($urandom_range(0, 15));
         step("mid");
      end
      rst_n = 1'b0;
      step("mid_rst");
      chk("mid_rst_zero", sin_o[1], 48'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rf_in = 4'($urandom_range(0, 15));
         step("mid_post");
         chk("mid_post_neg", 48'(sin_o[1][11:0]), w12(-300));
      end

      // random traffic
      for (int k = 0; k < 300; k++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         rf_in    = 4'($urandom_range(0, 15));
         sat_clr  = ($urandom_range(0, 9) == 0);
         for (int c = 0; c < NC; c++) set_ch(c, rnd_x(), rnd_x(), $urandom_range(0, 3));
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
